// File: rtl/dcache_pkg.sv
// Shared types and constants for the D-cache miss/refill sequencer.
// Line geometry: 32-bit address = {tag[19:0], index[7:0], byte offset[3:0]}.
package dcache_pkg;

    localparam int TAG_W  = 20;
    localparam int IDX_W  = 8;
    localparam int BEATS  = 4;
    localparam int WORD_W = 32;
    localparam int LINE_W = WORD_W * BEATS;
    localparam int CNT_W  = $clog2(BEATS);

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [LINE_W-1:0] line_t;

    typedef enum logic [2:0] {
        IDLE,
        WB_REQ,
        WB_RESP,
        RD_REQ,
        RD_DATA,
        REFILL
    } refill_state_t;

    function automatic logic [31:0] line_addr(input logic [TAG_W-1:0] tag,
                                              input logic [IDX_W-1:0] idx);
        return {tag, idx, 4'b0000};
    endfunction

endpackage

// File: rtl/dcache_wb_addr_latch.sv
// Captures the victim line address (way-selected tag + miss index) when a miss is accepted.
module dcache_wb_addr_latch
    import dcache_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             way_sel,
    input  logic [TAG_W-1:0] r_tagv1,
    input  logic [TAG_W-1:0] r_tagv2,
    input  logic [IDX_W-1:0] idx,
    output logic [31:0]      wb_addr
);

    logic [31:0] wb_addr_q;
    logic [31:0] wb_addr_d;

    always_comb begin
        wb_addr_d = wb_addr_q;
        if (load) begin
            wb_addr_d = line_addr(way_sel ? r_tagv2 : r_tagv1, idx);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_addr_q <= '0;
        end else begin
            wb_addr_q <= wb_addr_d;
        end
    end

    assign wb_addr = wb_addr_q;

endmodule

// File: rtl/dcache_refill_ctrl.sv
// D-cache miss sequencer: optional dirty-victim write-back, 4-beat line fetch,
// then a single-cycle write of the assembled line into the chosen way.
module dcache_refill_ctrl
    import dcache_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             miss_req,
    input  logic [31:0]      miss_addr,
    input  logic             way_sel,
    input  logic             victim_dirty,
    input  logic [TAG_W-1:0] r_tagv1,
    input  logic [TAG_W-1:0] r_tagv2,
    input  line_t            victim_line,
    output logic             d_wreq,
    output logic [31:0]      d_waddr,
    output line_t            d_wdata,
    input  logic             d_wrdy,
    input  logic             d_bvalid,
    output logic             d_rreq,
    output logic [31:0]      d_raddr,
    input  logic             d_rrdy,
    input  logic             d_rvalid,
    input  logic [31:0]      d_rdata,
    input  logic             d_rlast,
    output logic             refill_we,
    output logic             refill_way,
    output logic [IDX_W-1:0] refill_idx,
    output logic [TAG_W-1:0] refill_tag,
    output line_t            refill_data,
    output logic             busy,
    output logic             done
);

    refill_state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0] miss_addr_q, miss_addr_d;
    logic way_q, way_d;
    line_t victim_q, victim_d;
    word_t [BEATS-1:0] words_q, words_d;
    logic load;
    logic [31:0] wb_addr;

    assign load = (state_q == IDLE) && miss_req;

    dcache_wb_addr_latch u_wb_addr (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .way_sel (way_sel),
        .r_tagv1 (r_tagv1),
        .r_tagv2 (r_tagv2),
        .idx     (miss_addr[11:4]),
        .wb_addr (wb_addr)
    );

    always_comb begin
        // NOTE: every variable takes its held value first, so no branch of the case can infer a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        miss_addr_d = miss_addr_q;
        way_d       = way_q;
        victim_d    = victim_q;
        words_d     = words_q;
        case (state_q)
            IDLE: if (miss_req) begin
                miss_addr_d = miss_addr;
                way_d       = way_sel;
                victim_d    = victim_line;
                state_d     = victim_dirty ? WB_REQ : RD_REQ;
            end
            // A response arriving with the acceptance completes the write-back at once.
            WB_REQ:  if (d_wrdy) state_d = d_bvalid ? RD_REQ : WB_RESP;
            WB_RESP: if (d_bvalid) state_d = RD_REQ;
            RD_REQ: if (d_rrdy) begin
                state_d = RD_DATA;
                cnt_d   = '0;
            end
            RD_DATA: if (d_rvalid) begin
                words_d[cnt_q] = d_rdata;
                cnt_d          = cnt_q + CNT_W'(1);
                if (d_rlast) state_d = REFILL;
            end
            REFILL:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        d_wreq      = 1'b0;
        d_waddr     = '0;
        d_wdata     = '0;
        d_rreq      = 1'b0;
        d_raddr     = '0;
        refill_we   = 1'b0;
        refill_way  = 1'b0;
        refill_idx  = '0;
        refill_tag  = '0;
        refill_data = '0;
        done        = 1'b0;
        busy        = (state_q != IDLE);
        case (state_q)
            WB_REQ: begin
                d_wreq  = 1'b1;
                d_waddr = wb_addr;
                d_wdata = victim_q;
            end
            RD_REQ: begin
                d_rreq  = 1'b1;
                d_raddr = line_addr(miss_addr_q[31:12], miss_addr_q[11:4]);
            end
            REFILL: begin
                refill_we   = 1'b1;
                refill_way  = way_q;
                refill_idx  = miss_addr_q[11:4];
                refill_tag  = miss_addr_q[31:12];
                refill_data = words_q;
                done        = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            miss_addr_q <= '0;
            way_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            miss_addr_q <= miss_addr_d;
            way_q       <= way_d;
        end
    end

    // NOTE: the data buffers are not reset; they only reach outputs in states that follow a full load.
    always_ff @(posedge clk) begin
        victim_q <= victim_d;
        words_q  <= words_d;
    end

    a_rlast_on_final_beat: assert property (@(posedge clk) disable iff (rst)
        (state_q == RD_DATA && d_rvalid && d_rlast) |-> (cnt_q == CNT_W'(BEATS - 1)));

    a_no_data_before_addr: assert property (@(posedge clk) disable iff (rst)
        (state_q == RD_REQ) |-> !d_rvalid);

endmodule

// File: tb/tb_dcache_refill_ctrl.sv
// Directed + randomized bench for dcache_refill_ctrl with a transaction-level reference model.
module tb_dcache_refill_ctrl;
    import dcache_pkg::*;

    logic             clk = 1'b0;
    logic             rst;
    logic             miss_req;
    logic [31:0]      miss_addr;
    logic             way_sel;
    logic             victim_dirty;
    logic [TAG_W-1:0] r_tagv1, r_tagv2;
    line_t            victim_line;
    logic             d_wreq;
    logic [31:0]      d_waddr;
    line_t            d_wdata;
    logic             d_wrdy, d_bvalid;
    logic             d_rreq;
    logic [31:0]      d_raddr;
    logic             d_rrdy, d_rvalid;
    logic [31:0]      d_rdata;
    logic             d_rlast;
    logic             refill_we, refill_way;
    logic [IDX_W-1:0] refill_idx;
    logic [TAG_W-1:0] refill_tag;
    line_t            refill_data;
    logic             busy, done;

    dcache_refill_ctrl dut (
        .clk(clk), .rst(rst), .miss_req(miss_req), .miss_addr(miss_addr),
        .way_sel(way_sel), .victim_dirty(victim_dirty), .r_tagv1(r_tagv1),
        .r_tagv2(r_tagv2), .victim_line(victim_line), .d_wreq(d_wreq),
        .d_waddr(d_waddr), .d_wdata(d_wdata), .d_wrdy(d_wrdy), .d_bvalid(d_bvalid),
        .d_rreq(d_rreq), .d_raddr(d_raddr), .d_rrdy(d_rrdy), .d_rvalid(d_rvalid),
        .d_rdata(d_rdata), .d_rlast(d_rlast), .refill_we(refill_we),
        .refill_way(refill_way), .refill_idx(refill_idx), .refill_tag(refill_tag),
        .refill_data(refill_data), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]      addr;
        logic             way;
        logic             dirty;
        logic [TAG_W-1:0] tag1;
        logic [TAG_W-1:0] tag2;
        line_t            victim;
        logic [31:0]      beats [4];
        int               wrdy_dly;
        int               bresp_dly;
        int               rrdy_dly;
        int               gap_max;
        bit               same_cyc;
        bit               poke;
    } miss_t;

    int pass_cnt = 0;
    int total    = 0;
    int cyc      = 0;
    int we_cnt   = 0;
    int exp_we   = 0;

    always @(negedge clk) if (refill_we === 1'b1) we_cnt++;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Reference model: expected bus/SRAM values derived from address arithmetic.
    function automatic logic [31:0] exp_waddr(input miss_t m);
        logic [31:0] t;
        t = m.way ? 32'(m.tag2) : 32'(m.tag1);
        return (t << 12) | (m.addr & 32'h0000_0FF0);
    endfunction

    function automatic line_t exp_line(input miss_t m);
        line_t l = '0;
        for (int b = 0; b < 4; b++) l = l | (line_t'(m.beats[b]) << (32 * b));
        return l;
    endfunction

    function automatic miss_t rand_miss();
        miss_t m;
        m.addr      = $urandom;
        m.way       = 1'($urandom_range(0, 1));
        m.dirty     = 1'($urandom_range(0, 1));
        m.tag1      = TAG_W'($urandom);
        m.tag2      = TAG_W'($urandom);
        m.victim    = {$urandom, $urandom, $urandom, $urandom};
        for (int b = 0; b < 4; b++) m.beats[b] = $urandom;
        m.wrdy_dly  = $urandom_range(0, 3);
        m.bresp_dly = $urandom_range(0, 3);
        m.rrdy_dly  = $urandom_range(0, 2);
        m.gap_max   = $urandom_range(0, 2);
        m.same_cyc  = 1'($urandom_range(0, 1));
        m.poke      = 1'b1;
        return m;
    endfunction

    // Optionally raise a spurious miss for one cycle while the controller is busy.
    task automatic busy_cycle(input miss_t m);
        if (m.poke) begin
            miss_req  = 1'($urandom_range(0, 1));
            miss_addr = $urandom;
        end
        step();
        miss_req = 1'b0;
    endtask

    task automatic do_miss(input miss_t m, input int abort_beats, input bit check_lat);
        int start;
        int gaps;
        miss_req     = 1'b1;
        miss_addr    = m.addr;
        way_sel      = m.way;
        victim_dirty = m.dirty;
        r_tagv1      = m.tag1;
        r_tagv2      = m.tag2;
        victim_line  = m.victim;
        check("idle_busy", busy, 1'b0);
        start = cyc;
        step();
        miss_req     = 1'b0;
        miss_addr    = $urandom;
        way_sel      = ~m.way;
        r_tagv1      = TAG_W'($urandom);
        r_tagv2      = TAG_W'($urandom);
        victim_line  = ~m.victim;
        check("busy_after_miss", busy, 1'b1);

        if (m.dirty) begin
            for (int i = 0; i < m.wrdy_dly; i++) begin
                check("wreq_wait", d_wreq, 1'b1);
                check("waddr_stable", d_waddr, exp_waddr(m));
                check("rreq_during_wb", d_rreq, 1'b0);
                busy_cycle(m);
            end
            check("wreq", d_wreq, 1'b1);
            check("waddr", d_waddr, exp_waddr(m));
            check("wdata", d_wdata, m.victim);
            d_wrdy   = 1'b1;
            d_bvalid = m.same_cyc;
            step();
            d_wrdy   = 1'b0;
            d_bvalid = 1'b0;
            if (!m.same_cyc) begin
                check("wreq_drop", d_wreq, 1'b0);
                for (int i = 0; i < m.bresp_dly; i++) begin
                    check("rreq_before_bvalid", d_rreq, 1'b0);
                    busy_cycle(m);
                end
                check("rreq_before_bvalid", d_rreq, 1'b0);
                d_bvalid = 1'b1;
                step();
                d_bvalid = 1'b0;
            end
        end

        check("rreq", d_rreq, 1'b1);
        check("raddr", d_raddr, m.addr & 32'hFFFF_FFF0);
        for (int i = 0; i < m.rrdy_dly; i++) begin
            busy_cycle(m);
            check("rreq_hold", d_rreq, 1'b1);
            check("raddr_hold", d_raddr, m.addr & 32'hFFFF_FFF0);
        end
        d_rrdy = 1'b1;
        step();
        d_rrdy = 1'b0;
        check("rreq_drop", d_rreq, 1'b0);

        for (int b = 0; b < 4; b++) begin
            if (b == abort_beats) begin
                #2 rst = 1'b1;
                #1;
                check("rst_busy", busy, 1'b0);
                check("rst_rreq", d_rreq, 1'b0);
                check("rst_wreq", d_wreq, 1'b0);
                check("rst_we", refill_we, 1'b0);
                check("rst_done", done, 1'b0);
                check("rst_raddr", d_raddr, 32'h0);
                check("rst_data", refill_data, 128'h0);
                @(posedge clk);
                #3 rst = 1'b0;
                step();
                return;
            end
            gaps = (m.gap_max > 0) ? int'($urandom_range(1, m.gap_max)) : 0;
            for (int g = 0; g < gaps; g++) begin
                d_rdata = $urandom;
                check("no_we_in_gap", refill_we, 1'b0);
                busy_cycle(m);
            end
            d_rvalid = 1'b1;
            d_rdata  = m.beats[b];
            d_rlast  = (b == 3);
            step();
            d_rvalid = 1'b0;
            d_rlast  = 1'b0;
            d_rdata  = $urandom;
        end

        exp_we++;
        check("refill_we", refill_we, 1'b1);
        check("done", done, 1'b1);
        check("refill_way", refill_way, m.way);
        check("refill_idx", refill_idx, IDX_W'(m.addr >> 4));
        check("refill_tag", refill_tag, TAG_W'(m.addr >> 12));
        check("refill_data", refill_data, exp_line(m));
        if (check_lat) check("latency", 128'(cyc - start), 128'(6));
        step();
        check("we_pulse_end", refill_we, 1'b0);
        check("done_pulse_end", done, 1'b0);
        check("busy_end", busy, 1'b0);
    endtask

    initial begin
        miss_t m;
        rst = 1'b1;
        miss_req = 1'b0; miss_addr = '0; way_sel = 1'b0; victim_dirty = 1'b0;
        r_tagv1 = '0; r_tagv2 = '0; victim_line = '0;
        d_wrdy = 1'b0; d_bvalid = 1'b0; d_rrdy = 1'b0; d_rvalid = 1'b0;
        d_rdata = '0; d_rlast = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", busy, 1'b0);
        check("reset_wreq", d_wreq, 1'b0);
        check("reset_rreq", d_rreq, 1'b0);
        check("reset_we", refill_we, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_waddr", d_waddr, 32'h0);
        check("reset_raddr", d_raddr, 32'h0);
        check("reset_data", refill_data, 128'h0);
        rst = 1'b0;
        step();

        // Clean miss, zero-wait bridge.
        m = rand_miss();
        m.addr = 32'h1C00_0A34; m.dirty = 1'b0; m.way = 1'b0;
        m.beats[0] = 32'h11; m.beats[1] = 32'h22; m.beats[2] = 32'h33; m.beats[3] = 32'h44;
        m.rrdy_dly = 0; m.gap_max = 0; m.poke = 1'b0;
        do_miss(m, -1, 1'b1);
        check("clean_line_const", refill_data, 128'h0);

        // Dirty miss to way 2 with a delayed write response.
        m = rand_miss();
        m.addr = 32'h1C00_0A34; m.dirty = 1'b1; m.way = 1'b1; m.tag2 = 20'h8000F;
        m.wrdy_dly = 0; m.bresp_dly = 2; m.same_cyc = 1'b0; m.poke = 1'b0;
        check("dirty_waddr_model", exp_waddr(m), 32'h8000_FA30);
        do_miss(m, -1, 1'b0);

        // Backpressure on write acceptance and read beats, with spurious misses.
        m = rand_miss();
        m.dirty = 1'b1; m.wrdy_dly = 3; m.bresp_dly = 1; m.same_cyc = 1'b0;
        m.rrdy_dly = 2; m.gap_max = 2;
        do_miss(m, -1, 1'b0);

        // Write acceptance and response in the same cycle.
        m = rand_miss();
        m.dirty = 1'b1; m.same_cyc = 1'b1; m.wrdy_dly = 1;
        do_miss(m, -1, 1'b0);

        // Reset after two beats, then a fresh full refill.
        m = rand_miss();
        m.dirty = 1'b0;
        do_miss(m, 2, 1'b0);
        m = rand_miss();
        m.dirty = 1'b0; m.rrdy_dly = 0; m.gap_max = 0; m.poke = 1'b0;
        do_miss(m, -1, 1'b1);

        for (int i = 0; i < 12; i++) begin
            m = rand_miss();
            do_miss(m, -1, 1'b0);
        end

        step();
        check("refill_we_count", 128'(we_cnt), 128'(exp_we));
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule

// File: doc/dcache_refill_ctrl.md
Name: dcache_refill_ctrl

Overview:
- Sequences a D-cache miss: latches the miss address and victim way, optionally writes back the dirty victim line, fetches the new line as a 4-beat read burst, then writes it into the selected way.
- Sits between the D-cache pipeline (miss/hit logic, tag/data SRAMs) and the AXI bridge.
- Owns the write-back address register and the refill line buffer.

Parameters:
- TAG_W, 20, tag width; address bits [31:12].
- IDX_W, 8, index width; address bits [11:4].
- BEATS, 4, 32-bit beats per 128-bit line.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- miss_req  in  1  pipeline reports miss; sampled only in IDLE
- miss_addr  in  32  missing byte address
- way_sel  in  1  victim way (0 = way1, 1 = way2)
- victim_dirty  in  1  victim line dirty
- r_tagv1  in  TAG_W  way1 tag at miss index
- r_tagv2  in  TAG_W  way2 tag at miss index
- victim_line  in  128  victim data, valid with miss_req
- d_wreq  out  1  write-back request to bridge
- d_waddr  out  32  write-back line address
- d_wdata  out  128  write-back line data
- d_wrdy  in  1  bridge accepted write request
- d_bvalid  in  1  write response
- d_rreq  out  1  refill read request
- d_raddr  out  32  refill line address {tag,idx,4'b0}
- d_rrdy  in  1  bridge accepted read request
- d_rvalid  in  1  read beat valid
- d_rdata  in  32  read beat
- d_rlast  in  1  last beat
- refill_we  out  1  one-cycle SRAM write strobe
- refill_way  out  1  way to write
- refill_idx  out  IDX_W  index to write
- refill_tag  out  TAG_W  new tag; valid set, dirty cleared
- refill_data  out  128  assembled line, beat0 in [31:0]
- busy  out  1  stall pipeline
- done  out  1  one-cycle pulse, refill complete

Behaviour:
- Reset values: state IDLE; all outputs 0; beat counter 0.
- IDLE:
  - busy=0.
  - On miss_req=1 (same cycle), latch:
    - miss_addr, way_sel;
    - wb_addr = {way_sel ? r_tagv2 : r_tagv1, miss_addr[11:4], 4'b0};
    - victim_line.
  - Go to WB_REQ if victim_dirty, else RD_REQ.
  - busy=1 from the next cycle.
- WB_REQ:
  - d_wreq=1; d_waddr, d_wdata held stable.
  - On d_wrdy: drop d_wreq the next cycle and go to WB_RESP.
- WB_RESP: wait for d_bvalid, then go to RD_REQ.
- RD_REQ:
  - d_rreq=1, d_raddr={miss_addr[31:4],4'b0}.
  - On d_rrdy: drop d_rreq and go to RD_DATA; beat counter := 0.
- RD_DATA: each d_rvalid stores d_rdata into word[cnt], then cnt++ (2-bit, wraps).
  - d_rlast with cnt==3: go to REFILL.
  - d_rlast with cnt!=3: protocol error; still go to REFILL; sim assertion fires.
  - d_rvalid=0 cycles: hold.
- REFILL:
  - One cycle: refill_we=1, refill_way/idx/tag/data from latched values.
  - done=1 in the same cycle; next state IDLE.
  - busy deasserts the following cycle.
- A miss_req arriving while not IDLE is ignored; the pipeline is stalled by busy.
- d_wrdy and d_bvalid asserted in the same cycle while in WB_REQ: accept the request and treat the response as received; go directly to RD_REQ.
- d_rrdy with d_rvalid in the same cycle: the beat is not captured in RD_REQ. The bridge must not return data before the address is accepted; assert on violation.
- Reset mid-operation: return to IDLE immediately and abort any outstanding request. The bridge is reset by the same rst.
- Latency, clean miss with zero-wait bridge: miss_req at cycle 0 → refill_we at cycle 0+1(RD_REQ)+4 beats+1 = cycle 6.

Decomposition:
- Package dcache_pkg:
  - state enum refill_state_t {IDLE, WB_REQ, WB_RESP, RD_REQ, RD_DATA, REFILL};
  - TAG_W/IDX_W/BEATS constants;
  - line_t (128-bit) typedef.
- One sub-module, dcache_wb_addr_latch: way-muxed tag + index → line address register, enabled by the IDLE & miss_req load.

Test Plan:
- Clean miss: addr 0x1C00_0A34, victim_dirty=0, zero-wait bridge, beats 0x11,0x22,0x33,0x44 → d_raddr=0x1C00_0A30; refill_data=0x00000044_00000033_00000022_00000011, refill_idx=0xA3, refill_tag=0x1C000; refill_we/done at cycle 6.
- Dirty miss: way_sel=1, r_tagv2=0x8000F, addr 0x1C00_0A34 → d_waddr=0x8000_FA30 with d_wdata=victim_line. No d_rreq until d_bvalid is seen; then refill of way 1.
- Backpressure: d_wrdy delayed 3 cycles, d_rvalid gaps between beats → d_wreq/d_waddr stable until accepted; beats captured only on d_rvalid; line correct.
- Same-cycle d_wrdy+d_bvalid → goes straight to RD_REQ next cycle.
- Reset asserted during RD_DATA after 2 beats → all outputs 0 asynchronously. A subsequent miss performs a full fresh refill with counter starting at 0.
- miss_req pulsed while busy → ignored; exactly one refill_we per accepted miss.
